bus_rr_router: RTL and testbench

- Per-bus packet router sitting between the device FIFOs (`drvrs` devices on each of `bits` parallel buses) and the shared bus.
- Each bus runs an independent round-robin arbiter: it pops one packet from a pending device and pushes it to the device addressed in the packet header, or to all other devices on broadcast.
- Invalid or self-addressed packets are dropped and counted.
- Successor to the plain push/pop bus interface: adds arbitration, addressing, broadcast and error accounting.

---
 rtl/bus_rr_router.sv | 106 ++++++++++
 tb/tb_bus_rr_router.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_router.sv
// Per-bus round-robin packet router: each bus pops one pending device FIFO,
// then delivers the packet to its header destination, to every other device on broadcast, or drops it.
module bus_rr_router #(
    parameter int         bits      = 1,
    parameter int         pckg_sz   = 16,
    parameter int         drvrs     = 4,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng    [bits][drvrs],
    input  logic [pckg_sz-1:0] D_pop    [bits][drvrs],
    output logic               pop      [bits][drvrs],
    output logic               push     [bits][drvrs],
    output logic [pckg_sz-1:0] D_push   [bits][drvrs],
    output logic [15:0]        drop_cnt [bits]
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {S_IDLE, S_POP, S_PUSH} state_t;

    genvar gi, gj;
    generate
        for (gi = 0; gi < bits; gi++) begin : gen_bus
            state_t             state_q;
            logic [IW-1:0]      win_q;
            logic [IW-1:0]      rr_q;
            logic [IW-1:0]      sel_d;
            logic               found_d;
            logic [pckg_sz-1:0] pkt_q;
            logic [15:0]        drop_q;
            logic [15:0]        drop_d;
            logic [7:0]         dest;
            logic               is_bcast;
            logic               is_ucast;

            assign dest     = pkt_q[pckg_sz-1 -: 8];
            assign is_bcast = (dest == broadcast);
            assign is_ucast = (dest < 8'(drvrs)) && (dest != 8'(win_q));

            // Search starts just after the last served device so it ends up lowest priority.
            always_comb begin
                found_d = 1'b0;
                sel_d   = rr_q;
                for (int k = 1; k <= drvrs; k++) begin
                    if (!found_d && pndng[gi][IW'((int'(rr_q) + k) % drvrs)]) begin
                        found_d = 1'b1;
                        sel_d   = IW'((int'(rr_q) + k) % drvrs);
                    end
                end
            end

            always_comb begin
                drop_d = drop_q;
                if (state_q == S_PUSH && !is_bcast && !is_ucast && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= S_IDLE;
                    win_q   <= '0;
                    rr_q    <= IW'(drvrs - 1);
                    pkt_q   <= '0;
                    drop_q  <= '0;
                end else begin
                    drop_q <= drop_d;
                    case (state_q)
                        S_IDLE: begin
                            if (found_d) begin
                                win_q   <= sel_d;
                                state_q <= S_POP;
                            end
                        end
                        S_POP: begin
                            // A winner that withdrew its request is abandoned without touching the pointer.
                            if (pndng[gi][win_q]) begin
                                pkt_q   <= D_pop[gi][win_q];
                                rr_q    <= win_q;
                                state_q <= S_PUSH;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                        S_PUSH:  state_q <= S_IDLE;
                        default: state_q <= S_IDLE;
                    endcase
                end
            end

            for (gj = 0; gj < drvrs; gj++) begin : gen_dev
                assign pop[gi][gj]    = !reset && (state_q == S_POP) && (win_q == IW'(gj))
                                        && pndng[gi][gj];
                assign push[gi][gj]   = !reset && (state_q == S_PUSH)
                                        && (is_bcast ? (win_q != IW'(gj))
                                                     : (is_ucast && dest == 8'(gj)));
                assign D_push[gi][gj] = pkt_q;
            end

            assign drop_cnt[gi] = drop_q;
        end
    endgenerate

endmodule

// File: tb/tb_bus_rr_router.sv
// Bench for bus_rr_router: device FIFOs modelled as arrays, expected pops/pushes/drops
// derived from the routing rules (round-robin winner, header decode, 3-cycle cadence).
module tb_bus_rr_router;

    localparam int NB = 2;
    localparam int ND = 4;
    localparam int PW = 16;
    localparam int QD = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          pndng    [NB][ND];
    logic [PW-1:0] D_pop    [NB][ND];
    logic          pop      [NB][ND];
    logic          push     [NB][ND];
    logic [PW-1:0] D_push   [NB][ND];
    logic [15:0]   drop_cnt [NB];

    bus_rr_router #(
        .bits      (NB),
        .pckg_sz   (PW),
        .drvrs     (ND),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // device FIFOs
    logic [15:0] mem [NB][ND][QD];
    int          head [NB][ND];
    int          tail [NB][ND];
    bit          popd_obs [NB][ND];

    bit check_on;
    int cyc;

    // reference model state
    int          last_srv [NB];
    int          win_p    [NB];
    bit          idle_p   [NB];
    bit          anyp_p   [NB];
    bit          popped_p [NB];
    logic [15:0] pkt_p    [NB];
    logic [15:0] dhold    [NB];
    logic [15:0] mdrop    [NB];

    // observation records for directed checks
    int          pop_cyc  [NB];
    int          push_cyc [NB];
    logic [3:0]  push_seen [NB];
    int          popseq   [NB][256];
    int          npop     [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [15:0] p, input int src);
        logic [7:0] dst;
        logic [3:0] m;
        dst = p[15:8];
        m   = 4'b0000;
        if (dst == 8'hFF)
            m = 4'hF & ~(4'b0001 << src);
        else if (dst < 8'd4 && int'(dst) != src)
            m = 4'b0001 << dst;
        return m;
    endfunction

    function automatic bit nonempty(input int b, input int d);
        return head[b][d] < tail[b][d];
    endfunction

    function automatic bit any_pending();
        bit r;
        r = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++)
                if (nonempty(b, d)) r = 1'b1;
        return r;
    endfunction

    task automatic enq(input int b, input int d, input logic [15:0] p);
        mem[b][d][tail[b][d]] = p;
        tail[b][d]++;
    endtask

    task automatic tick(input logic rst);
        logic [3:0] pv, sv, ep, es;
        bit         np, ni;
        int         dd;
        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++)
                if (popd_obs[b][d]) head[b][d]++;
        reset = rst;
        for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++) begin
                pndng[b][d] = nonempty(b, d);
                D_pop[b][d] = pndng[b][d] ? mem[b][d][head[b][d]] : 16'h0000;
            end
        #1;
        cyc++;
        for (int b = 0; b < NB; b++) begin
            ep = 4'b0000;
            es = 4'b0000;
            if (!rst) begin
                if (idle_p[b] && anyp_p[b]) ep[win_p[b]] = 1'b1;
                if (popped_p[b]) es = exp_mask(pkt_p[b], last_srv[b]);
            end
            for (int d = 0; d < ND; d++) begin
                pv[d] = pop[b][d];
                sv[d] = push[b][d];
                popd_obs[b][d] = pop[b][d];
            end
            if (pv != 4'b0000) begin
                pop_cyc[b] = cyc;
                for (int d = 0; d < ND; d++)
                    if (pv[d]) begin
                        popseq[b][npop[b]] = d;
                        npop[b]++;
                    end
            end
            if (sv != 4'b0000) begin
                push_cyc[b]  = cyc;
                push_seen[b] = sv;
            end
            if (check_on) begin
                chk($sformatf("pop b%0d c%0d", b, cyc), 32'(pv), 32'(ep));
                chk($sformatf("push b%0d c%0d", b, cyc), 32'(sv), 32'(es));
                for (int d = 0; d < ND; d++)
                    chk($sformatf("dpush b%0d d%0d c%0d", b, d, cyc), 32'(D_push[b][d]), 32'(dhold[b]));
                chk($sformatf("drop b%0d c%0d", b, cyc), 32'(drop_cnt[b]), 32'(mdrop[b]));
            end
            if (rst) begin
                idle_p[b]   = 1'b0;
                anyp_p[b]   = 1'b0;
                popped_p[b] = 1'b0;
                last_srv[b] = ND - 1;
                pkt_p[b]    = 16'h0000;
                dhold[b]    = 16'h0000;
                mdrop[b]    = 16'h0000;
            end else begin
                np = (ep != 4'b0000);
                if (popped_p[b] && es == 4'b0000 && mdrop[b] != 16'hFFFF) mdrop[b]++;
                if (np) begin
                    pkt_p[b]    = mem[b][win_p[b]][head[b][win_p[b]]];
                    dhold[b]    = pkt_p[b];
                    last_srv[b] = win_p[b];
                end
                ni          = !(idle_p[b] && anyp_p[b]) && !popped_p[b];
                popped_p[b] = np;
                idle_p[b]   = ni;
                anyp_p[b]   = 1'b0;
                if (ni) begin
                    for (int k = 1; k <= ND; k++) begin
                        dd = (last_srv[b] + k) % ND;
                        if (!anyp_p[b] && nonempty(b, dd)) begin
                            anyp_p[b] = 1'b1;
                            win_p[b]  = dd;
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (any_pending() && k < bound) begin
            tick(1'b0);
            k++;
        end
        chk("drain_bound", 32'(k < bound), 32'd1);
        repeat (4) tick(1'b0);
    endtask

    initial begin
        int          t0;
        int          s;
        int          r;
        logic [7:0]  dst;

        reset = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int d = 0; d < ND; d++) begin
                pndng[b][d]    = 1'b0;
                D_pop[b][d]    = 16'h0000;
                head[b][d]     = 0;
                tail[b][d]     = 0;
                popd_obs[b][d] = 1'b0;
            end
            last_srv[b] = ND - 1;
            win_p[b]    = 0;
            idle_p[b]   = 1'b0;
            anyp_p[b]   = 1'b0;
            popped_p[b] = 1'b0;
            pkt_p[b]    = 16'h0000;
            dhold[b]    = 16'h0000;
            mdrop[b]    = 16'h0000;
            pop_cyc[b]  = -1;
            push_cyc[b] = -1;
            push_seen[b] = 4'b0000;
            npop[b]     = 0;
        end
        check_on = 1'b0;
        cyc = 0;

        // reset state
        tick(1'b1);
        check_on = 1'b1;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        chk("reset_drop0", 32'(drop_cnt[0]), 32'd0);
        chk("reset_drop1", 32'(drop_cnt[1]), 32'd0);

        // unicast dev0 -> dev2
        enq(0, 0, 16'h02AB);
        t0 = cyc + 1;
        repeat (5) tick(1'b0);
        chk("uni_pop_cycle", 32'(pop_cyc[0]), 32'(t0 + 1));
        chk("uni_push_cycle", 32'(push_cyc[0]), 32'(t0 + 2));
        chk("uni_push_mask", 32'(push_seen[0]), 32'b0100);
        chk("uni_drop", 32'(drop_cnt[0]), 32'd0);

        // broadcast from dev1
        enq(0, 1, 16'hFF55);
        repeat (5) tick(1'b0);
        chk("bcast_mask", 32'(push_seen[0]), 32'b1101);

        // round-robin out of reset, all devices pending
        tick(1'b1);
        tick(1'b0);
        s = npop[0];
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < 2; k++)
                enq(0, d, {8'((d + 1) % ND), 8'(d * 16 + k)});
        drain(200);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order_%0d", i), 32'(popseq[0][s + i]), 32'(i % ND));

        // drops: out of range and self-addressed
        tick(1'b1);
        tick(1'b0);
        enq(0, 3, 16'h0711);
        enq(0, 3, 16'h0300);
        drain(200);
        chk("drop_two", 32'(drop_cnt[0]), 32'd2);

        // saturation
        force dut.gen_bus[0].drop_q = 16'hFFFD;
        #1;
        release dut.gen_bus[0].drop_q;
        mdrop[0] = 16'hFFFD;
        enq(0, 2, 16'h0200);
        enq(0, 2, 16'h0901);
        enq(0, 2, 16'h0433);
        enq(0, 2, 16'h0255);
        drain(200);
        chk("drop_sat", 32'(drop_cnt[0]), 32'hFFFF);

        // reset during the push cycle
        tick(1'b1);
        tick(1'b0);
        enq(0, 0, 16'h0122);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("rst_no_push", 32'(push_cyc[0] == cyc), 32'd0);
        tick(1'b0);
        chk("rst_drop", 32'(drop_cnt[0]), 32'd0);
        chk("rst_consumed", 32'(nonempty(0, 0)), 32'd0);
        s = npop[0];
        enq(0, 2, 16'h0310);
        enq(0, 0, 16'h0231);
        drain(200);
        chk("rst_first_dev", 32'(popseq[0][s]), 32'd0);
        chk("rst_second_dev", 32'(popseq[0][s + 1]), 32'd2);

        // both buses start together
        tick(1'b1);
        tick(1'b0);
        enq(0, 0, 16'h0111);
        enq(1, 2, 16'h0022);
        t0 = cyc + 1;
        repeat (5) tick(1'b0);
        chk("par_push_cycle0", 32'(push_cyc[0]), 32'(t0 + 2));
        chk("par_push_cycle1", 32'(push_cyc[1]), 32'(t0 + 2));
        chk("par_mask0", 32'(push_seen[0]), 32'b0010);
        chk("par_mask1", 32'(push_seen[1]), 32'b0001);

        // randomized traffic on both buses
        tick(1'b1);
        tick(1'b0);
        for (int b = 0; b < NB; b++)
            for (int d = 0; d < ND; d++)
                for (int k = 0; k < 6; k++) begin
                    r = int'($urandom_range(0, 9));
                    if (r < 4)       dst = 8'(r);
                    else if (r == 4) dst = 8'hFF;
                    else if (r == 5) dst = 8'h07;
                    else             dst = 8'($urandom_range(0, 3));
                    enq(b, d, {dst, 8'($urandom)});
                end
        drain(1000);
        chk("rand_empty", 32'(any_pending()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
